// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared DDRAM geometry, opcode masks and instruction decode for the LCD bus
package lcd_pkg;

  localparam logic [6:0] LINE1_BASE  = 7'h00;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [6:0] LINE_END    = 7'h27;
  localparam int         VISIBLE_LEN = 16;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISPLAY,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } instr_e;

  // The instruction class is chosen by the highest set bit of the opcode.
  function automatic instr_e decode_instr(input logic [7:0] op);
    if ((op & OP_DDRAM) != 8'h00)   return INS_DDRAM;
    if ((op & OP_CGRAM) != 8'h00)   return INS_CGRAM;
    if ((op & OP_FUNC) != 8'h00)    return INS_FUNC;
    if ((op & OP_SHIFT) != 8'h00)   return INS_SHIFT;
    if ((op & OP_DISPLAY) != 8'h00) return INS_DISPLAY;
    if ((op & OP_ENTRY) != 8'h00)   return INS_ENTRY;
    if ((op & OP_HOME) != 8'h00)    return INS_HOME;
    if ((op & OP_CLEAR) != 8'h00)   return INS_CLEAR;
    return INS_NOP;
  endfunction

endpackage

// File: rtl/lcd_ac_stepper.sv
// rtl/lcd_ac_stepper.sv - next address counter value with the two-line DDRAM wrap rules
module lcd_ac_stepper
  import lcd_pkg::*;
(
  input  logic [6:0] ac_i,
  input  logic       inc_i,
  output logic [6:0] ac_next_o
);

  localparam logic [6:0] LINE2_END = LINE2_BASE | LINE_END;

  always_comb begin
    ac_next_o = inc_i ? ac_i + 7'd1 : ac_i - 7'd1;
    if (inc_i) begin
      if (ac_i == LINE_END)       ac_next_o = LINE2_BASE;
      else if (ac_i == LINE2_END) ac_next_o = LINE1_BASE;
    end else begin
      if (ac_i == LINE1_BASE)      ac_next_o = LINE2_END;
      else if (ac_i == LINE2_BASE) ac_next_o = LINE_END;
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - KS0066/HD44780 bus responder with 2x16 DDRAM shadow; nibble mode under LCD_RESPONDER_4BIT_EN
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter logic [15:0] BUSY_CYCLES       = 16'd40,
  parameter logic [15:0] CLEAR_BUSY_CYCLES = 16'd1600
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic [7:0]   DB_in,
  input  logic         RS,
  input  logic         E,
  input  logic         RW,
  output logic [7:0]   DB_out,
  output logic         DB_oe,
  output logic [127:0] lineA,
  output logic [127:0] lineB,
  output logic [6:0]   ac,
  output logic         busy,
  output logic         display_on,
  output logic         wr_evt,
  output logic         protocol_err
);

  logic       e_s1_q, e_s2_q, e_d_q, rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0] db_s1_q, db_s2_q;
  logic       rs_lat_q, rw_lat_q;
  logic [7:0] db_lat_q;

  logic [127:0] line_a_q, line_b_q;
  logic [6:0]   ac_q;
  logic         id_q, display_on_q, wr_evt_q, protocol_err_q;
  logic [15:0]  busy_cnt_q;

  logic       strobe, wr_strobe, exec_en, step_inc;
  logic [7:0] exec_byte, rd_word, rd_byte;
  logic [6:0] ac_step, bit_base;
  instr_e     instr;

  assign strobe    = e_d_q & ~e_s2_q;
  assign wr_strobe = strobe & ~rw_lat_q;
  assign busy      = (busy_cnt_q != 16'd0);
  assign rd_word   = {busy, ac_q};

`ifdef LCD_RESPONDER_4BIT_EN
  logic       nibble_mode_q, wr_phase_q, rd_phase_q;
  logic [3:0] nib_hi_q;

  assign exec_en   = wr_strobe & (~nibble_mode_q | wr_phase_q);
  assign exec_byte = nibble_mode_q ? {nib_hi_q, db_lat_q[7:4]} : db_lat_q;
  assign rd_byte   = !nibble_mode_q ? rd_word :
                     rd_phase_q ? {rd_word[3:0], 4'h0} : {rd_word[7:4], 4'h0};
`else
  assign exec_en   = wr_strobe;
  assign exec_byte = db_lat_q;
  assign rd_byte   = rd_word;
`endif

  assign instr    = decode_instr(exec_byte);
  assign step_inc = rs_lat_q ? id_q : exec_byte[2];
  assign bit_base = {ac_q[3:0], 3'b000};

  lcd_ac_stepper u_stepper (
    .ac_i      (ac_q),
    .inc_i     (step_inc),
    .ac_next_o (ac_step)
  );

  always_ff @(posedge mclk) begin
    if (rst) begin
      {e_s1_q, e_s2_q, e_d_q}  <= '0;
      {rs_s1_q, rs_s2_q}       <= '0;
      {rw_s1_q, rw_s2_q}       <= '0;
      {db_s1_q, db_s2_q}       <= '0;
      {rs_lat_q, rw_lat_q}     <= '0;
      db_lat_q                 <= '0;
      line_a_q                 <= {VISIBLE_LEN{CHAR_SPACE}};
      line_b_q                 <= {VISIBLE_LEN{CHAR_SPACE}};
      ac_q                     <= '0;
      id_q                     <= 1'b1;
      display_on_q             <= 1'b0;
      wr_evt_q                 <= 1'b0;
      protocol_err_q           <= 1'b0;
      busy_cnt_q               <= '0;
`ifdef LCD_RESPONDER_4BIT_EN
      {nibble_mode_q, wr_phase_q, rd_phase_q} <= '0;
      nib_hi_q                 <= '0;
`endif
    end else begin
      e_s1_q  <= E;      e_s2_q  <= e_s1_q;  e_d_q <= e_s2_q;
      rs_s1_q <= RS;     rs_s2_q <= rs_s1_q;
      rw_s1_q <= RW;     rw_s2_q <= rw_s1_q;
      db_s1_q <= DB_in;  db_s2_q <= db_s1_q;
      // Hold the bus fields seen while E was high so the falling edge uses them.
      if (e_s2_q) begin
        rs_lat_q <= rs_s2_q;
        rw_lat_q <= rw_s2_q;
        db_lat_q <= db_s2_q;
      end
      wr_evt_q <= 1'b0;
      if (busy) busy_cnt_q <= busy_cnt_q - 16'd1;
      if (wr_strobe && busy) protocol_err_q <= 1'b1;
`ifdef LCD_RESPONDER_4BIT_EN
      if (wr_strobe && nibble_mode_q) begin
        wr_phase_q <= ~wr_phase_q;
        nib_hi_q   <= db_lat_q[7:4];
      end
      if (strobe && rw_lat_q && nibble_mode_q) rd_phase_q <= ~rd_phase_q;
`endif
      if (exec_en) begin
        if (rs_lat_q) begin
          if (ac_q[5:4] == 2'b00) begin
            if (ac_q[6]) line_b_q[bit_base +: 8] <= exec_byte;
            else         line_a_q[bit_base +: 8] <= exec_byte;
            wr_evt_q <= 1'b1;
          end
          ac_q       <= ac_step;
          busy_cnt_q <= BUSY_CYCLES;
        end else begin
          case (instr)
            INS_DDRAM:   begin ac_q <= exec_byte[6:0]; busy_cnt_q <= BUSY_CYCLES; end
            INS_CGRAM:   busy_cnt_q <= BUSY_CYCLES;
            INS_FUNC: begin
`ifdef LCD_RESPONDER_4BIT_EN
              nibble_mode_q <= ~exec_byte[4];
`endif
              busy_cnt_q <= BUSY_CYCLES;
            end
            INS_SHIFT: begin
              if (!exec_byte[3]) ac_q <= ac_step;
              busy_cnt_q <= BUSY_CYCLES;
            end
            INS_DISPLAY: begin display_on_q <= exec_byte[2]; busy_cnt_q <= BUSY_CYCLES; end
            INS_ENTRY:   begin id_q <= exec_byte[1]; busy_cnt_q <= BUSY_CYCLES; end
            INS_HOME:    begin ac_q <= '0; busy_cnt_q <= CLEAR_BUSY_CYCLES; end
            INS_CLEAR: begin
              line_a_q   <= {VISIBLE_LEN{CHAR_SPACE}};
              line_b_q   <= {VISIBLE_LEN{CHAR_SPACE}};
              ac_q       <= '0;
              id_q       <= 1'b1;
              busy_cnt_q <= CLEAR_BUSY_CYCLES;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign DB_oe        = e_s2_q & rw_s2_q;
  assign DB_out       = DB_oe ? rd_byte : 8'h00;
  assign lineA        = line_a_q;
  assign lineB        = line_b_q;
  assign ac           = ac_q;
  assign display_on   = display_on_q;
  assign wr_evt       = wr_evt_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - directed-vector bench for lcd_bus_responder
module tb_lcd_bus_responder;

  logic         mclk = 1'b0;
  logic         rst  = 1'b1;
  logic [7:0]   DB_in = 8'h00;
  logic         RS = 1'b0, E = 1'b0, RW = 1'b0;
  logic [7:0]   DB_out;
  logic         DB_oe;
  logic [127:0] lineA, lineB;
  logic [6:0]   ac;
  logic         busy, display_on, wr_evt, protocol_err;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int base;

  localparam logic [127:0] SPACES = {16{8'h20}};

  lcd_bus_responder dut (
    .mclk(mclk), .rst(rst), .DB_in(DB_in), .RS(RS), .E(E), .RW(RW),
    .DB_out(DB_out), .DB_oe(DB_oe), .lineA(lineA), .lineB(lineB), .ac(ac),
    .busy(busy), .display_on(display_on), .wr_evt(wr_evt), .protocol_err(protocol_err)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) if (wr_evt === 1'b1) wr_cnt = wr_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge mclk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge mclk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", {127'd0, busy}, 128'd0);
  endtask

  // Full bus cycle: setup, E high, falling edge; returns right after E drops.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] db);
    @(negedge mclk);
    RS = rs; RW = rw; DB_in = db;
    repeat (3) @(negedge mclk);
    E = 1'b1;
    repeat (4) @(negedge mclk);
    E = 1'b0;
  endtask

  task automatic bus_wr(input logic rs, input logic [7:0] db);
    strobe(rs, 1'b0, db);
    settle();
    wait_idle();
  endtask

  initial begin
    int n, guard;
    repeat (5) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    chk("rst_lineA", lineA, SPACES);
    chk("rst_lineB", lineB, SPACES);
    chk("rst_ac", {121'd0, ac}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_display_on", {127'd0, display_on}, 128'd0);
    chk("rst_db_oe", {127'd0, DB_oe}, 128'd0);
    chk("rst_db_out", {120'd0, DB_out}, 128'd0);
    chk("rst_wr_evt", {127'd0, wr_evt}, 128'd0);
    chk("rst_perr", {127'd0, protocol_err}, 128'd0);

    // Clear display: busy must last exactly CLEAR_BUSY_CYCLES.
    strobe(1'b0, 1'b0, 8'h01);
    n = 0; guard = 0;
    do begin
      @(negedge mclk);
      guard++;
      if (busy === 1'b1) n++;
    end while ((n == 0 || busy === 1'b1) && guard < 3000);
    chk("clear_busy_len", n, 1600);
    chk("clear_lineA", lineA, SPACES);
    chk("clear_lineB", lineB, SPACES);
    chk("clear_ac", {121'd0, ac}, 128'd0);

    bus_wr(1'b0, 8'h0C);
    chk("display_on", {127'd0, display_on}, 128'd1);

    base = wr_cnt;
    bus_wr(1'b0, 8'h85);
    bus_wr(1'b1, 8'h41);
    chk("data_cell5", lineA[47:40], 8'h41);
    chk("data_ac", {121'd0, ac}, 128'h06);
    chk("data_wr_evt", wr_cnt - base, 1);

    base = wr_cnt;
    bus_wr(1'b0, 8'hA7);
    bus_wr(1'b1, 8'h58);
    chk("drop_ac_wrap", {121'd0, ac}, 128'h40);
    chk("drop_no_evt", wr_cnt - base, 0);
    bus_wr(1'b1, 8'h59);
    chk("line2_cell0", lineB[7:0], 8'h59);
    chk("line2_ac", {121'd0, ac}, 128'h41);
    chk("line2_wr_evt", wr_cnt - base, 1);

    bus_wr(1'b0, 8'h04);
    bus_wr(1'b0, 8'hC0);
    bus_wr(1'b1, 8'h78);
    chk("dec_cell", lineB[7:0], 8'h78);
    chk("dec_ac_wrap", {121'd0, ac}, 128'h27);

    // Read during busy, then a write during busy.
    strobe(1'b0, 1'b0, 8'h8A);
    settle();
    @(negedge mclk);
    RS = 1'b0; RW = 1'b1;
    repeat (3) @(negedge mclk);
    E = 1'b1;
    repeat (3) @(negedge mclk);
    chk("read_oe", {127'd0, DB_oe}, 128'd1);
    chk("read_data", {120'd0, DB_out}, 128'h8A);
    E = 1'b0;
    repeat (3) @(negedge mclk);
    chk("read_oe_low", {127'd0, DB_oe}, 128'd0);
    chk("read_ac_kept", {121'd0, ac}, 128'h0A);
    chk("read_no_perr", {127'd0, protocol_err}, 128'd0);
    strobe(1'b1, 1'b0, 8'h33);
    settle();
    chk("busy_wr_perr", {127'd0, protocol_err}, 128'd1);
    chk("busy_wr_busy", {127'd0, busy}, 128'd1);
    chk("busy_wr_cell", lineA[87:80], 8'h33);
    chk("busy_wr_ac", {121'd0, ac}, 128'h09);
    wait_idle();
    repeat (10) @(negedge mclk);
    chk("perr_sticky", {127'd0, protocol_err}, 128'd1);

    rst = 1'b1;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    chk("rerst_perr", {127'd0, protocol_err}, 128'd0);
    chk("rerst_lineA", lineA, SPACES);

    // Cursor shifts and their wraps; display shift and no-op leave ac alone.
    bus_wr(1'b0, 8'h14);
    chk("shift_right", {121'd0, ac}, 128'h01);
    bus_wr(1'b0, 8'h10);
    chk("shift_left", {121'd0, ac}, 128'h00);
    bus_wr(1'b0, 8'h10);
    chk("shift_left_wrap", {121'd0, ac}, 128'h67);
    bus_wr(1'b0, 8'h14);
    chk("shift_right_wrap", {121'd0, ac}, 128'h00);
    bus_wr(1'b0, 8'h1C);
    chk("display_shift", {121'd0, ac}, 128'h00);
    strobe(1'b0, 1'b0, 8'h00);
    settle();
    chk("nop_no_busy", {127'd0, busy}, 128'd0);

    // Reset while E is high: the pending strobe must be discarded.
    base = wr_cnt;
    @(negedge mclk);
    RS = 1'b1; RW = 1'b0; DB_in = 8'h55;
    repeat (3) @(negedge mclk);
    E = 1'b1;
    repeat (3) @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    E = 1'b0;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    repeat (6) @(negedge mclk);
    chk("midrst_cell", lineA[7:0], 8'h20);
    chk("midrst_no_evt", wr_cnt - base, 0);
    chk("midrst_ac", {121'd0, ac}, 128'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Receiving end of the KS0066/HD44780 parallel bus (DB/RS/E/RW) that the team's LCD write controller drives.
- Decodes instruction and data strobes, maintains a 2x16 visible DDRAM shadow, address counter and busy flag, and answers read cycles with {BF, AC}.
- Two uses:
  - Loop-back monitor in simulation and on the Vaman board: the reconstructed lineA/lineB is compared against what the clock display requested.
  - Behavioural LCD stand-in for benches.

Parameters:
BUSY_CYCLES, 16'd40, mclk cycles busy after a normal instruction or data write
CLEAR_BUSY_CYCLES, 16'd1600, mclk cycles busy after clear display or return home

Ports:
mclk  input  1  main clock
rst  input  1  synchronous, active-high reset
DB_in  input  8  bus data from the LCD controller
RS  input  1  register select (0 = instruction, 1 = data)
E  input  1  enable strobe; writes latch on its falling edge
RW  input  1  1 = read cycle, 0 = write cycle
DB_out  output  8  read data {BF, AC[6:0]}
DB_oe  output  1  high while DB_out is driven
lineA  output  128  visible line 1; lineA[8*i+:8] = cell at DDRAM address 0x00+i (i = 0 is leftmost)
lineB  output  128  visible line 2; lineB[8*i+:8] = cell at DDRAM address 0x40+i
ac  output  7  current address counter
busy  output  1  busy flag
display_on  output  1  D bit from the last display on/off control instruction
wr_evt  output  1  one-cycle pulse when a data byte is stored into a visible cell
protocol_err  output  1  sticky; set by any write strobe that arrives while busy = 1

Behaviour:
- Reset values: lineA and lineB = {16{8'h20}}; ac = 0; I/D = 1; busy = 0; display_on = 0; DB_out = 0; DB_oe = 0; wr_evt = 0; protocol_err = 0.
- Synchronisation: E, RS, RW and DB_in each pass through a 2-flop synchroniser.
- Strobe detection: a strobe is the synchronised E going 1 -> 0. RS, RW and DB are taken from the synchronised sample of the last cycle in which E was high.
- Bus timing: DB/RS/RW must be stable for >= 2 mclk on either side of the E falling edge.
- Latency: state and outputs update 3 mclk after the E falling edge at the pins.
- Read cycle (RW = 1): DB_oe = 1 and DB_out = {busy, ac} for every cycle that the synchronised E = 1. The falling edge of a read has no effect on state.
- Write, RS = 1 (data):
  - If ac is 0x00-0x0F or 0x40-0x4F, store the byte in that cell and pulse wr_evt.
  - Any other address: the byte is dropped.
  - Then step ac by I/D and load busy with BUSY_CYCLES.
- Write, RS = 0 (instruction): decoded on the highest set bit.
  - 1aaaaaaa: ac = aaaaaaa.
  - 01xxxxxx: CGRAM address; accepted, otherwise ignored.
  - 001xxxxx: function set; ignored unless LCD_RESPONDER_4BIT_EN is defined.
  - 0001 S/C R/L xx: if S/C = 0, step ac (R/L = 1 increments, R/L = 0 decrements); display shifts are ignored.
  - 00001 D C B: display_on = D.
  - 000001 I/D S: latch I/D; S is ignored.
  - 0000001x: ac = 0; busy loaded with CLEAR_BUSY_CYCLES.
  - 00000001: all 32 cells = 0x20; ac = 0; I/D = 1; busy loaded with CLEAR_BUSY_CYCLES.
  - 00000000: no-op; busy is not loaded.
  - All other accepted instructions load busy with BUSY_CYCLES.
- Busy counter: busy = (counter != 0); the counter decrements once per mclk.
- ac stepping rules:
  - Increment wraps 0x27 -> 0x40 and 0x67 -> 0x00.
  - Decrement wraps 0x00 -> 0x67 and 0x40 -> 0x27.
  - Outside the ranges 0x00-0x27 and 0x40-0x67, ac steps by +/-1 modulo 128.
- Strobe while busy: the strobe is still executed, protocol_err is set, and busy is reloaded.
- Reset asserted mid-cycle: the strobe in flight is discarded and the synchroniser flops are cleared to 0.

Optional Feature:
LCD_RESPONDER_4BIT_EN
- Defined:
  - A function set with DL = 0 selects nibble mode; DL = 1 returns to 8-bit mode.
  - In nibble mode each byte takes two write strobes on DB_in[7:4], high nibble first. Execution happens on the second strobe.
  - A nibble-phase flag toggles on every write strobe and is cleared by reset.
  - A read returns the high nibble on the first strobe and the low nibble on the second.
- Not defined: DL is ignored and the bus is always 8-bit.

Decomposition:
- Shared header lcd_pkg holds:
  - instruction opcode masks;
  - LINE1_BASE = 7'h00, LINE2_BASE = 7'h40, LINE_END = 7'h27, VISIBLE_LEN = 16;
  - CHAR_SPACE = 8'h20.
- One sub-module, lcd_ac_stepper: combinational next-ac computation (ac, inc/dec) -> ac_next, implementing the wrap rules. It is reused by the write controller's cursor tracking.

Test Plan:
- Reset, then strobe 0x01 -> lineA and lineB all 0x20, ac = 0, busy high for exactly CLEAR_BUSY_CYCLES.
- Strobe 0x85 then data 0x41 -> lineA[47:40] = 0x41, ac = 0x06, exactly one wr_evt pulse.
- Strobe 0xA7, then data 0x58 and data 0x59 -> 0x58 is dropped (no wr_evt), ac passes 0x27 -> 0x40, lineB[7:0] = 0x59, ac = 0x41.
- Strobe 0x04, then 0xC0, then data 0x78 -> lineB[7:0] = 0x78, ac = 0x27.
- Read cycle (RW = 1, RS = 0) during busy after 0x8A -> DB_out = 8'h8A, DB_oe high only while E is high. A write strobe during busy -> protocol_err = 1 and stays set until rst.
- Connect the team's lcd_controller with a known clock display pattern -> after one refresh period, lineA and lineB equal the driven lines byte-for-byte.
